dp_rr_scheduler: RTL and testbench
==================================

// Module: dp_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares one registered 16-bit datapath stage among
//  N_REQ requesters. It grants one owner at a time and moves that owner's beats
//  into the shared output register under a valid/ready handshake. A grant ends on
//  the owner's last beat, at the burst limit, or if the owner drops its request.
//  Sits between the producer blocks and the single downstream 16-bit data register.
// PARAMETERS
//  N_REQ      4   number of requesters (2..8)
//  DATA_W     16  datapath width
//  MAX_BURST  4   max beats per grant (1..2^CNT_W-1)
//  CNT_W      8   width of beat counters
// PORTS
//  clk          in   1             single clock, rising edge
//  rst          in   1             asynchronous, active-high reset
//  req          in   N_REQ         per-requester beat valid; must stay high while waiting
//  req_data     in   N_REQ*DATA_W  requester i uses bits [i*DATA_W +: DATA_W]
//  req_last     in   N_REQ         marks the final beat of requester i's burst
//  gnt          out  N_REQ         one-hot grant (registered); all-zero when no owner
//  ack          out  N_REQ         combinational; beat of requester i accepted this cycle
//  dp_data      out  DATA_W        shared datapath register
//  dp_valid     out  1             dp_data holds an unconsumed beat
//  dp_ready     in   1             downstream consumes dp_data when dp_valid&dp_ready
//  busy         out  1             high in GRANT/RELEASE states
//  beat_count   out  CNT_W         total beats accepted since reset; wraps
// BEHAVIOUR
//  Reset: gnt=0, dp_valid=0, dp_data=0, busy=0, beat_count=0, burst_cnt=0,
//   ptr=0, state=IDLE. Asserting rst at any time (including mid-burst) drops any
//   in-flight beat; nothing is replayed.
//  load_en = !dp_valid | dp_ready (one-entry pipeline; full-throughput when ready=1).
//  ack[i] = gnt[i] & req[i] & load_en; at most one bit set.
//  FSM:
//   IDLE: if |req, owner = first requester i with req[i], searching ptr, ptr+1, ...
//     mod N_REQ. Next cycle: gnt=onehot(owner), burst_cnt=0, state GRANT.
//     If no requests, stay in IDLE. Arbitration latency: 1 cycle from req to gnt.
//   GRANT: on ack: dp_data<=req_data[owner], dp_valid<=1, burst_cnt++,
//     beat_count++ (mod 2^CNT_W). Move to RELEASE in these cases:
//     ack & req_last[owner]; ack & burst_cnt+1==MAX_BURST; or !req[owner] (abort).
//     The last case counts as burst end.
//   RELEASE: gnt=0 for exactly 1 cycle, ptr<=(owner+1) mod N_REQ, then IDLE.
//     Minimum gap between two grants: 2 cycles.
//  dp_valid clears on dp_ready when no new load; dp_data is held stable while
//   dp_valid & !dp_ready. Accept and consume can occur in the same cycle
//   (back-to-back beats).
//  Simultaneous: when requests arrive in RELEASE, they are arbitrated in IDLE using
//   the updated ptr. A lone requester may be re-granted after RELEASE
//   (no starvation, no skipping).
//  beat_count wraps 2^CNT_W-1 -> 0 with no flag.
// STRUCTURE
//  Shared package dp_sched_pkg: state encoding (IDLE, GRANT, RELEASE), default
//   DATA_W/N_REQ/MAX_BURST constants, onehot/index helper function.
//  Sub-module dp_rr_pick: combinational rotate-priority picker (req, ptr -> idx,
//   found). All registers stay in dp_rr_scheduler.
// TESTING
//  T1 reset: rst=1 mid-burst with dp_valid=1 -> next edge gnt=0, dp_valid=0,
//   dp_data=0, beat_count=0, state IDLE.
//  T2 single burst: req[1]=1, data 0x1111,0x2222,0x3333, last on 3rd, dp_ready=1
//   -> gnt=4'b0010 1 cycle after req; dp_data sequence 0x1111,0x2222,0x3333 on
//   consecutive cycles; gnt=0 for 1 cycle; beat_count=3.
//  T3 fairness: req=4'b1111 held, never last, MAX_BURST=4 -> owners 0,1,2,3,0;
//   each grant has 4 acks; 2-cycle gap between grants.
//  T4 backpressure: dp_ready=0 for 5 cycles during the T2 burst -> dp_data held at
//   0x1111, ack=0 during the stall, no beat lost or duplicated.
//  T5 abort: req[2] drops after 1 beat -> RELEASE next cycle, ptr=3; a pending
//   req[0] is granted before req[2] re-raises.
//  T6 wrap: 256 beats accepted -> beat_count returns to 0x00.

Source files
------------

// File: rtl/dp_sched_pkg.sv
// Shared state encoding, default sizes and index helper for the round-robin
// datapath scheduler.
package dp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } sched_state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_CNT_W     = 8;

  // Next requester index after idx, wrapping back to 0 at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dp_rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping.
module dp_rr_pick
  import dp_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = IDX_W'(wrap_inc(32'(cand), N_REQ));
    end
  end

endmodule

// File: rtl/dp_rr_scheduler.sv
// Round-robin scheduler sharing one registered datapath stage among N_REQ
// requesters under a valid/ready handshake.
module dp_rr_scheduler
  import dp_sched_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       dp_data,
  output logic                    dp_valid,
  input  logic                    dp_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        beat_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_t      state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [CNT_W-1:0]  burst_cnt;
  logic              load_en;
  logic              owner_ack;
  logic              owner_req;
  logic              owner_last;
  logic              burst_end;
  logic [DATA_W-1:0] owner_data;

  dp_rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .idx  (pick_idx),
    .found(pick_found)
  );

  // The output register is a one-entry pipeline: it can reload whenever it is
  // empty or being drained in the same cycle.
  assign load_en    = !dp_valid || dp_ready;
  assign ack        = gnt & req & {N_REQ{load_en}};
  assign owner_ack  = |ack;
  assign owner_req  = req[owner];
  assign owner_last = req_last[owner];
  assign burst_end  = owner_last || (burst_cnt + CNT_W'(1) == CNT_W'(MAX_BURST));

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == IDX_W'(i)) owner_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      ptr        <= '0;
      gnt        <= '0;
      burst_cnt  <= '0;
      busy       <= 1'b0;
      dp_data    <= '0;
      dp_valid   <= 1'b0;
      beat_count <= '0;
    end else begin
      if (owner_ack) begin
        dp_data    <= owner_data;
        dp_valid   <= 1'b1;
        beat_count <= beat_count + CNT_W'(1);
      end else if (dp_ready) begin
        dp_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            owner     <= pick_idx;
            gnt       <= N_REQ'(1) << pick_idx;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (owner_ack) burst_cnt <= burst_cnt + CNT_W'(1);
          // A dropped request ends the grant exactly like a completed burst.
          if ((owner_ack && burst_end) || !owner_req) begin
            gnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          ptr   <= IDX_W'(wrap_inc(32'(owner), N_REQ));
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_rr_scheduler.sv
// Self-checking bench for dp_rr_scheduler: per-scenario tasks plus a scoreboard
// that checks every beat consumed from the shared datapath register.
module tb_dp_rr_scheduler;

  localparam int N_REQ     = 4;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       dp_data;
  logic                    dp_valid;
  logic                    dp_ready;
  logic                    busy;
  logic [CNT_W-1:0]        beat_count;

  int vectors     = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] sb_q [$];
  logic [DATA_W-1:0] sb_exp;

  always #5 clk = ~clk;

  dp_rr_scheduler #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .ack(ack), .dp_data(dp_data), .dp_valid(dp_valid),
    .dp_ready(dp_ready), .busy(busy), .beat_count(beat_count)
  );

  // Every consumed beat must be the oldest expected beat.
  always @(posedge clk) begin
    if (!rst && dp_valid && dp_ready) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_extra_beat: got dp_data=%h consumed, required no beat", dp_data);
      end else begin
        sb_exp = sb_q.pop_front();
        if (dp_data !== sb_exp) begin
          miscompares++;
          $display("[TB] FAIL sb_data: got %h, required %h", dp_data, sb_exp);
        end
      end
    end
  end

  task automatic set_data(input int i, input logic [DATA_W-1:0] d);
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req_last = '0; req_data = '0; dp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (gnt != '0) begin ok = 1'b1; break; end
    end
  endtask

  // Called at a negedge; waits for requester i's beat to be acked, then drops it.
  task automatic finish_beat(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (ack[i]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    req[i] = 1'b0; req_last[i] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++; if (gnt !== '0) begin miscompares++; $display("[TB] FAIL rst_gnt: got %b, required 0000", gnt); end
    vectors++; if (dp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid: got %b, required 0", dp_valid); end
    vectors++; if (dp_data !== '0) begin miscompares++; $display("[TB] FAIL rst_data: got %h, required 0000", dp_data); end
    vectors++; if (beat_count !== '0) begin miscompares++; $display("[TB] FAIL rst_count: got %0d, required 0", beat_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b, required 0", busy); end
    @(posedge clk); #1;
    req = 4'b1000; set_data(3, 16'hABCD); dp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (dp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pre_valid: got %b, required 1", dp_valid); end
    vectors++; if (gnt !== 4'b1000) begin miscompares++; $display("[TB] FAIL rst_pre_gnt: got %b, required 1000", gnt); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (gnt !== '0) begin miscompares++; $display("[TB] FAIL rst_mid_gnt: got %b, required 0000", gnt); end
    vectors++; if (dp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_valid: got %b, required 0", dp_valid); end
    vectors++; if (dp_data !== '0) begin miscompares++; $display("[TB] FAIL rst_mid_data: got %h, required 0000", dp_data); end
    vectors++; if (beat_count !== '0) begin miscompares++; $display("[TB] FAIL rst_mid_count: got %0d, required 0", beat_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_busy: got %b, required 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0; req = '0; dp_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (dp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_no_replay: got dp_valid=%b, required 0", dp_valid); end
  endtask

  task automatic test_single_burst();
    logic [DATA_W-1:0] beats [3];
    beats = '{16'h1111, 16'h2222, 16'h3333};
    do_reset();
    foreach (beats[k]) sb_q.push_back(beats[k]);
    req = 4'b0010; req_last = '0; set_data(1, beats[0]); dp_ready = 1'b1;
    @(negedge clk);
    vectors++; if (gnt !== '0) begin miscompares++; $display("[TB] FAIL sb_latency: got %b, required 0000", gnt); end
    @(negedge clk);
    vectors++; if (gnt !== 4'b0010) begin miscompares++; $display("[TB] FAIL sb_gnt: got %b, required 0010", gnt); end
    vectors++; if (ack !== 4'b0010) begin miscompares++; $display("[TB] FAIL sb_ack: got %b, required 0010", ack); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k < 2) begin set_data(1, beats[k+1]); req_last[1] = (k == 1); end
      else begin req = '0; req_last = '0; end
      @(negedge clk);
      vectors++; if (dp_data !== beats[k]) begin miscompares++; $display("[TB] FAIL sb_dp_data: got %h, required %h", dp_data, beats[k]); end
      vectors++; if (dp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_dp_valid: got %b, required 1", dp_valid); end
    end
    vectors++; if (gnt !== '0) begin miscompares++; $display("[TB] FAIL sb_release_gnt: got %b, required 0000", gnt); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_release_busy: got %b, required 1", busy); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL sb_idle_busy: got %b, required 0", busy); end
    vectors++; if (beat_count !== 8'd3) begin miscompares++; $display("[TB] FAIL sb_count: got %0d, required 3", beat_count); end
    vectors++; if (sb_q.size() != 0) begin miscompares++; $display("[TB] FAIL sb_drain: got %0d left, required 0", sb_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] beats [3];
    int idx;
    bit acked, done;
    beats = '{16'h1111, 16'h2222, 16'h3333};
    do_reset();
    foreach (beats[k]) sb_q.push_back(beats[k]);
    req = 4'b0010; req_last = '0; set_data(1, beats[0]); dp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 dp_ready = 1'b0; set_data(1, beats[1]);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      vectors++; if (ack !== '0) begin miscompares++; $display("[TB] FAIL bp_ack: got %b, required 0000", ack); end
      vectors++; if (dp_data !== 16'h1111) begin miscompares++; $display("[TB] FAIL bp_hold: got %h, required 1111", dp_data); end
      @(posedge clk);
    end
    #1 dp_ready = 1'b1;
    idx = 1; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk); acked = ack[1];
      @(posedge clk); #1;
      if (acked) begin
        if (idx == 2) begin req = '0; req_last = '0; done = 1'b1; end
        else begin idx++; set_data(1, beats[idx]); req_last[1] = (idx == 2); end
      end
    end
    repeat (3) @(negedge clk);
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL bp_timeout: got %0d beats, required 3", idx); end
    vectors++; if (sb_q.size() != 0) begin miscompares++; $display("[TB] FAIL bp_drain: got %0d left, required 0", sb_q.size()); end
    vectors++; if (beat_count !== 8'd3) begin miscompares++; $display("[TB] FAIL bp_count: got %0d, required 3", beat_count); end
  endtask

  task automatic test_fairness();
    int cnt [N_REQ];
    int grants, acks_in, gap;
    bit done;
    logic [N_REQ-1:0] prev, acked;
    do_reset();
    for (int g = 0; g < 5; g++)
      for (int k = 0; k < MAX_BURST; k++)
        sb_q.push_back(DATA_W'(((g % N_REQ) << 12) | ((g / N_REQ) * MAX_BURST + k)));
    for (int i = 0; i < N_REQ; i++) begin cnt[i] = 0; set_data(i, DATA_W'(i << 12)); end
    req = '1; req_last = '0; dp_ready = 1'b1;
    grants = 0; acks_in = 0; gap = 0; done = 1'b0; prev = '0;
    for (int c = 0; c < 120 && !done; c++) begin
      @(negedge clk);
      if (gnt != '0 && prev == '0) begin
        vectors++;
        if (gnt !== N_REQ'(1 << (grants % N_REQ))) begin
          miscompares++; $display("[TB] FAIL fair_owner: grant %0d got %b, required %b", grants, gnt, N_REQ'(1 << (grants % N_REQ)));
        end
        if (grants > 0) begin
          vectors++; if (gap != 2) begin miscompares++; $display("[TB] FAIL fair_gap: got %0d idle cycles, required 2", gap); end
        end
        grants++; acks_in = 0;
      end
      if (gnt == '0 && prev != '0) begin
        vectors++; if (acks_in != MAX_BURST) begin miscompares++; $display("[TB] FAIL fair_beats: got %0d acks, required %0d", acks_in, MAX_BURST); end
        if (grants == 5) done = 1'b1;
      end
      gap = (gnt == '0) ? gap + 1 : 0;
      acked = ack;
      if (ack != '0) acks_in++;
      prev = gnt;
      @(posedge clk); #1;
      for (int i = 0; i < N_REQ; i++)
        if (acked[i]) begin cnt[i]++; set_data(i, DATA_W'((i << 12) | cnt[i])); end
      if (done) req = '0;
    end
    repeat (3) @(negedge clk);
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL fair_timeout: got %0d grants, required 5", grants); end
    vectors++; if (sb_q.size() != 0) begin miscompares++; $display("[TB] FAIL fair_drain: got %0d left, required 0", sb_q.size()); end
    vectors++; if (beat_count !== 8'd20) begin miscompares++; $display("[TB] FAIL fair_count: got %0d, required 20", beat_count); end
  endtask

  task automatic test_abort();
    bit ok;
    do_reset();
    sb_q.push_back(16'h0A0A); sb_q.push_back(16'hC2C2);
    sb_q.push_back(16'hC0C0); sb_q.push_back(16'hC2C3);
    dp_ready = 1'b1; req = 4'b0010; req_last = 4'b0010; set_data(1, 16'h0A0A);
    @(negedge clk);
    finish_beat(1, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL ab_setup: got no ack, required ack[1]"); end
    req = 4'b0101; set_data(2, 16'hC2C2); set_data(0, 16'hC0C0); req_last[0] = 1'b1;
    wait_gnt(ok);
    vectors++; if (!ok || gnt !== 4'b0100) begin miscompares++; $display("[TB] FAIL ab_first: got %b, required 0100", gnt); end
    finish_beat(2, ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL ab_beat: got no ack, required ack[2]"); end
    @(negedge clk);
    vectors++; if (ack !== '0) begin miscompares++; $display("[TB] FAIL ab_no_ack: got %b, required 0000", ack); end
    @(posedge clk); #1;
    req[2] = 1'b1; set_data(2, 16'hC2C3); req_last[2] = 1'b1;
    @(negedge clk);
    vectors++; if (gnt !== '0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL ab_release: got gnt=%b busy=%b, required 0000/1", gnt, busy); end
    wait_gnt(ok);
    vectors++; if (!ok || gnt !== 4'b0001) begin miscompares++; $display("[TB] FAIL ab_pending0: got %b, required 0001", gnt); end
    finish_beat(0, ok);
    wait_gnt(ok);
    vectors++; if (!ok || gnt !== 4'b0100) begin miscompares++; $display("[TB] FAIL ab_regrant2: got %b, required 0100", gnt); end
    finish_beat(2, ok);
    repeat (3) @(negedge clk);
    vectors++; if (sb_q.size() != 0) begin miscompares++; $display("[TB] FAIL ab_drain: got %0d left, required 0", sb_q.size()); end
    vectors++; if (beat_count !== 8'd4) begin miscompares++; $display("[TB] FAIL ab_count: got %0d, required 4", beat_count); end
  endtask

  task automatic test_wrap();
    int n;
    bit acked;
    do_reset();
    for (int k = 0; k < 256; k++) sb_q.push_back(DATA_W'(k));
    req = 4'b0001; req_last = '0; set_data(0, '0); dp_ready = 1'b1; n = 0;
    for (int c = 0; c < 2000 && n < 256; c++) begin
      @(negedge clk); acked = ack[0];
      @(posedge clk); #1;
      if (acked) begin
        n++;
        set_data(0, DATA_W'(n));
        if (n == 255) begin
          vectors++; if (beat_count !== 8'hFF) begin miscompares++; $display("[TB] FAIL wrap_pre: got %h, required ff", beat_count); end
        end
        if (n == 256) req = '0;
      end
    end
    repeat (3) @(negedge clk);
    vectors++; if (n != 256) begin miscompares++; $display("[TB] FAIL wrap_timeout: got %0d beats, required 256", n); end
    vectors++; if (beat_count !== 8'h00) begin miscompares++; $display("[TB] FAIL wrap_count: got %h, required 00", beat_count); end
    vectors++; if (sb_q.size() != 0) begin miscompares++; $display("[TB] FAIL wrap_drain: got %0d left, required 0", sb_q.size()); end
  endtask

  initial begin
    req = '0; req_last = '0; req_data = '0; dp_ready = 1'b1;
    test_reset();
    test_single_burst();
    test_backpressure();
    test_fairness();
    test_abort();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
